// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: command codes, operand-valid
// codes, the operand wait limit and the command decoder.
// Optional feature macro: ALU_MULT_EN (enables arithmetic CMD 9/10).
`ifndef ALU_WIDTH
`define ALU_WIDTH 8
`endif
`ifndef ALU_CWIDTH
`define ALU_CWIDTH 4
`endif

package alu_pkg;
    localparam int DEF_WIDTH  = `ALU_WIDTH;
    localparam int DEF_CWIDTH = `ALU_CWIDTH;
    localparam int WAIT_LIMIT = 16;
    localparam int WAIT_CNT_W = 5;

    // INP_VALID encodings: bit0 = OPA present, bit1 = OPB present
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    typedef enum logic [3:0] {
        A_ADD = 4'd0, A_SUB = 4'd1, A_ADD_CIN = 4'd2, A_SUB_CIN = 4'd3,
        A_INC_A = 4'd4, A_DEC_A = 4'd5, A_INC_B = 4'd6, A_DEC_B = 4'd7,
        A_CMP = 4'd8, A_MUL_INC = 4'd9, A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND = 4'd0, L_NAND = 4'd1, L_OR = 4'd2, L_NOR = 4'd3,
        L_XOR = 4'd4, L_XNOR = 4'd5, L_NOT_A = 4'd6, L_NOT_B = 4'd7,
        L_SHR_A = 4'd8, L_SHL_A = 4'd9, L_SHR_B = 4'd10, L_SHL_B = 4'd11,
        L_ROL = 4'd12, L_ROR = 4'd13
    } logic_cmd_e;

    typedef enum logic {
        WS_IDLE = 1'b0,
        WS_WAIT = 1'b1
    } wait_state_e;

    // Returns {legal, need_b, need_a} for a command in the given mode
    function automatic logic [2:0] cmd_decode(input logic mode, input logic [3:0] cmd);
        logic [2:0] d;
        d = 3'b000;
        if (mode) begin
            case (cmd)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: d = 3'b111;
                A_INC_A, A_DEC_A:                          d = 3'b101;
                A_INC_B, A_DEC_B:                          d = 3'b110;
`ifdef ALU_MULT_EN
                A_MUL_INC, A_MUL_SHL:                      d = 3'b111;
`endif
                default:                                   d = 3'b000;
            endcase
        end else begin
            case (cmd)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: d = 3'b111;
                L_NOT_A, L_SHR_A, L_SHL_A:                               d = 3'b101;
                L_NOT_B, L_SHR_B, L_SHL_B:                               d = 3'b110;
                default:                                                 d = 3'b000;
            endcase
        end
        return d;
    endfunction
endpackage

// File: rtl/alu_operand_wait.sv
// Operand wait FSM: holds off a two-operand command until the missing
// operand shows up, or gives up after WAIT_LIMIT enabled cycles.
// o_ready/o_timeout are combinational and only take effect on a CE cycle.
module alu_operand_wait
    import alu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce,
    input  logic                  i_start,
    input  logic                  i_operand_in,
    output logic                  o_busy,
    output logic                  o_ready,
    output logic                  o_timeout,
    output wait_state_e           o_state,
    output logic [WAIT_CNT_W-1:0] o_count
);
    wait_state_e           r_state;
    wait_state_e           w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_count;
    logic [WAIT_CNT_W-1:0] w_count_nxt;

    // State and counter registers; CE low freezes both
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WS_IDLE;
            r_count <= '0;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state: enter on start, leave on arrival (wins over the limit) or timeout
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        o_ready     = 1'b0;
        o_timeout   = 1'b0;
        case (r_state)
            WS_IDLE: begin
                if (i_start) begin
                    w_state_nxt = WS_WAIT;
                    w_count_nxt = WAIT_CNT_W'(1);
                end
            end
            WS_WAIT: begin
                if (i_operand_in) begin
                    o_ready     = 1'b1;
                    w_state_nxt = WS_IDLE;
                    w_count_nxt = '0;
                end else if (r_count == WAIT_CNT_W'(WAIT_LIMIT)) begin
                    o_timeout   = 1'b1;
                    w_state_nxt = WS_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = WS_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign o_busy  = (r_state == WS_WAIT);
    assign o_state = r_state;
    assign o_count = r_count;
endmodule

// File: rtl/alu_design.sv
// Registered integer ALU (arithmetic MODE=1 / logical MODE=0) with compare
// flags, carry/borrow, error reporting and split operand delivery.
// Optional feature macro: ALU_MULT_EN (2-cycle multiply commands 9/10).
module alu_design
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CWIDTH-1:0]    CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 E,
    output logic                 L,
    output logic                 ERR,
    output wait_state_e          o_dbg_state
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] r_res;
    logic r_cout, r_oflow, r_g, r_e, r_l, r_err;
    logic [CWIDTH-1:0] r_cmd;
    logic r_mode, r_have_a;
    logic [WIDTH-1:0] r_opa, r_opb;

    logic w_busy, w_ready, w_timeout, w_start, w_issue, w_fail, w_load_now, w_mul_busy;
    logic w_mode, w_missing_in, w_legal;
    logic [CWIDTH-1:0] w_cmd;
    logic [WIDTH-1:0] w_a, w_b, w_log;
    logic [2:0] w_dec;
    logic [1:0] w_need;
    logic [WIDTH:0] w_tmp;
    logic [2*WIDTH-1:0] w_rot;
    logic [WAIT_CNT_W-1:0] w_wait_count;
    logic [2*WIDTH-1:0] c_res;
    logic c_cout, c_oflow, c_g, c_e, c_l, c_err, c_is_mul;

    alu_operand_wait u_wait (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_ce         (CE),
        .i_start      (w_start),
        .i_operand_in (w_missing_in),
        .o_busy       (w_busy),
        .o_ready      (w_ready),
        .o_timeout    (w_timeout),
        .o_state      (o_dbg_state),
        .o_count      (w_wait_count)
    );

    // While waiting, the latched command and operand replace the live inputs
    assign w_mode       = w_busy ? r_mode : MODE;
    assign w_cmd        = w_busy ? r_cmd : CMD;
    assign w_a          = (w_busy && r_have_a)  ? r_opa : OPA;
    assign w_b          = (w_busy && !r_have_a) ? r_opb : OPB;
    assign w_missing_in = r_have_a ? INP_VALID[1] : INP_VALID[0];
    assign w_dec        = cmd_decode(MODE, CMD[3:0]);
    assign w_legal      = w_dec[2] && ((CMD >> 4) == '0);
    assign w_need       = w_dec[1:0];

    // Issue control: decide between compute, error, start-wait or nothing
    always_comb begin
        w_start = 1'b0;
        w_issue = 1'b0;
        w_fail  = 1'b0;
        if (w_busy) begin
            if (w_ready)        w_issue = 1'b1;
            else if (w_timeout) w_fail  = 1'b1;
        end else if (!w_mul_busy && (INP_VALID != IV_NONE)) begin
            if (!w_legal)                                        w_fail  = 1'b1;
            else if ((w_need == IV_AB) && (INP_VALID != IV_AB))  w_start = 1'b1;
            else if ((INP_VALID & w_need) == w_need)             w_issue = 1'b1;
            else                                                 w_fail  = 1'b1;
        end
    end

    assign w_load_now = (w_issue && !c_is_mul) || w_fail;

    // Datapath: result and flags for the effective command and operands
    always_comb begin
        c_res = '0; c_cout = 1'b0; c_oflow = 1'b0;
        c_g = 1'b0; c_e = 1'b0; c_l = 1'b0; c_err = 1'b0; c_is_mul = 1'b0;
        w_tmp = '0; w_log = '0; w_rot = '0;
        if (w_mode) begin
            case (w_cmd[3:0])
                A_ADD:     begin w_tmp = {1'b0, w_a} + {1'b0, w_b}; c_cout = w_tmp[WIDTH]; end
                A_SUB:     begin w_tmp = {1'b0, w_a} - {1'b0, w_b}; c_oflow = (w_a < w_b); end
                A_ADD_CIN: begin
                    w_tmp  = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, CIN};
                    c_cout = w_tmp[WIDTH];
                end
                A_SUB_CIN: begin
                    w_tmp   = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, CIN};
                    c_oflow = ({1'b0, w_a} < ({1'b0, w_b} + {{WIDTH{1'b0}}, CIN}));
                end
                A_INC_A:   begin w_tmp = {1'b0, w_a} + ONE_X; c_cout = w_tmp[WIDTH]; end
                A_DEC_A:   begin w_tmp = {1'b0, w_a} - ONE_X; c_oflow = (w_a == '0); end
                A_INC_B:   begin w_tmp = {1'b0, w_b} + ONE_X; c_cout = w_tmp[WIDTH]; end
                A_DEC_B:   begin w_tmp = {1'b0, w_b} - ONE_X; c_oflow = (w_b == '0); end
                A_CMP:     begin c_g = (w_a > w_b); c_e = (w_a == w_b); c_l = (w_a < w_b); end
`ifdef ALU_MULT_EN
                A_MUL_INC: begin
                    c_is_mul = 1'b1;
                    c_res = (2*WIDTH)'({1'b0, w_a} + ONE_X) * (2*WIDTH)'({1'b0, w_b} + ONE_X);
                end
                A_MUL_SHL: begin
                    c_is_mul = 1'b1;
                    c_res = (2*WIDTH)'({w_a, 1'b0}) * (2*WIDTH)'(w_b);
                end
`endif
                default:   c_err = 1'b1;
            endcase
            if (!c_is_mul) c_res = {{(WIDTH-1){1'b0}}, w_tmp};
        end else begin
            case (w_cmd[3:0])
                L_AND:   w_log = w_a & w_b;
                L_NAND:  w_log = ~(w_a & w_b);
                L_OR:    w_log = w_a | w_b;
                L_NOR:   w_log = ~(w_a | w_b);
                L_XOR:   w_log = w_a ^ w_b;
                L_XNOR:  w_log = ~(w_a ^ w_b);
                L_NOT_A: w_log = ~w_a;
                L_NOT_B: w_log = ~w_b;
                L_SHR_A: w_log = w_a >> 1;
                L_SHL_A: w_log = w_a << 1;
                L_SHR_B: w_log = w_b >> 1;
                L_SHL_B: w_log = w_b << 1;
                L_ROL: begin
                    w_rot = {w_a, w_a} << w_b[SH_W-1:0];
                    w_log = w_rot[2*WIDTH-1:WIDTH];
                    c_err = ((w_b >> SH_W) != '0);
                end
                L_ROR: begin
                    w_rot = {w_a, w_a} >> w_b[SH_W-1:0];
                    w_log = w_rot[WIDTH-1:0];
                    c_err = ((w_b >> SH_W) != '0);
                end
                default: c_err = 1'b1;
            endcase
            c_res = {{WIDTH{1'b0}}, w_log};
        end
    end

`ifdef ALU_MULT_EN
    logic               r_mul_pend;
    logic [2*WIDTH-1:0] r_mul_res;

    // Multiply first stage: product held one extra cycle before it reaches RES
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mul_pend <= 1'b0;
            r_mul_res  <= '0;
        end else if (CE) begin
            r_mul_pend <= w_issue && c_is_mul;
            if (w_issue && c_is_mul) r_mul_res <= c_res;
        end
    end
    assign w_mul_busy = r_mul_pend;
`else
    assign w_mul_busy = 1'b0;
`endif

    // Output and operand-latch registers; flags/ERR are rewritten on every result
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res <= '0; r_cout <= 1'b0; r_oflow <= 1'b0;
            r_g <= 1'b0; r_e <= 1'b0; r_l <= 1'b0; r_err <= 1'b0;
            r_cmd <= '0; r_mode <= 1'b0; r_have_a <= 1'b0; r_opa <= '0; r_opb <= '0;
        end else if (CE) begin
            if (w_load_now) begin
                r_res   <= w_fail ? '0 : c_res;
                r_cout  <= !w_fail && c_cout;
                r_oflow <= !w_fail && c_oflow;
                r_g     <= !w_fail && c_g;
                r_e     <= !w_fail && c_e;
                r_l     <= !w_fail && c_l;
                r_err   <= w_fail || c_err;
            end
`ifdef ALU_MULT_EN
            else if (r_mul_pend) begin
                r_res <= r_mul_res; r_cout <= 1'b0; r_oflow <= 1'b0;
                r_g <= 1'b0; r_e <= 1'b0; r_l <= 1'b0; r_err <= 1'b0;
            end
`endif
            if (w_start) begin
                r_cmd    <= CMD;
                r_mode   <= MODE;
                r_opa    <= OPA;
                r_opb    <= OPB;
                r_have_a <= INP_VALID[0];
            end
        end
    end

    assign RES   = r_res;
    assign COUT  = r_cout;
    assign OFLOW = r_oflow;
    assign G     = r_g;
    assign E     = r_e;
    assign L     = r_l;
    assign ERR   = r_err;
endmodule

// File: tb/tb_alu_design.sv
// Directed self-checking bench for alu_design (default WIDTH=8, CWIDTH=4).
// Inputs change just after a negedge; outputs are checked at the next negedge.
module tb_alu_design;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    logic        mode = 1'b0;
    logic [3:0]  cmd = '0;
    logic [1:0]  iv = '0;
    logic [7:0]  opa = '0, opb = '0;
    logic        cin = 1'b0;
    logic [15:0] res;
    logic        cout, oflow, g, e, l, err;
    wait_state_e dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [21:0] exp_q[$];

    alu_design dut (
        .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .CMD(cmd), .INP_VALID(iv),
        .OPA(opa), .OPB(opb), .CIN(cin), .RES(res), .COUT(cout), .OFLOW(oflow),
        .G(g), .E(e), .L(l), .ERR(err), .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of inputs and wait for the following negedge
    task automatic step(input logic m, input logic [3:0] c, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
        mode = m; cmd = c; iv = v; opa = a; opb = b; cin = ci;
        @(negedge clk);
    endtask

    function automatic logic [21:0] pack(input logic [15:0] r, input logic co, input logic of,
                                         input logic gg, input logic ee, input logic ll,
                                         input logic er);
        return {r, co, of, gg, ee, ll, er};
    endfunction

    // Scoreboard: push the hand-computed expectation, pop and compare against outputs
    task automatic expect_out(input string tag, input logic [21:0] exp_v);
        logic [21:0] obs;
        logic [21:0] want;
        exp_q.push_back(exp_v);
        want = exp_q.pop_front();
        obs  = {res, cout, oflow, g, e, l, err};
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed res=%h c=%b o=%b g=%b e=%b l=%b err=%b expected res=%h c=%b o=%b g=%b e=%b l=%b err=%b",
                   tag, obs[21:6], obs[5], obs[4], obs[3], obs[2], obs[1], obs[0],
                   want[21:6], want[5], want[4], want[3], want[2], want[1], want[0]);
        end
    endtask

    task automatic expect_state(input string tag, input wait_state_e want);
        n_cmp++;
        assert (dbg_state === want) else begin
            n_err++;
            $error("FAIL %s: observed state=%0d expected state=%0d", tag, dbg_state, want);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(1'b1, A_ADD, IV_AB, 8'h12, 8'h34, 1'b0);
        step(1'b1, A_ADD, IV_AB, 8'h12, 8'h34, 1'b0);
        expect_out("reset_outputs", pack(16'h0000, 0, 0, 0, 0, 0, 0));
        expect_state("reset_state", WS_IDLE);
        rst = 1'b0;

        // Arithmetic
        step(1'b1, A_ADD, IV_AB, 8'hFF, 8'h01, 1'b0);
        expect_out("add_ff_01", pack(16'h0100, 1, 0, 0, 0, 0, 0));
        step(1'b1, A_SUB, IV_AB, 8'h03, 8'h05, 1'b0);
        expect_out("sub_3_5", pack(16'h01FE, 0, 1, 0, 0, 0, 0));
        step(1'b1, A_ADD_CIN, IV_AB, 8'h10, 8'h20, 1'b1);
        expect_out("add_cin", pack(16'h0031, 0, 0, 0, 0, 0, 0));
        step(1'b1, A_SUB_CIN, IV_AB, 8'h05, 8'h05, 1'b1);
        expect_out("sub_cin_borrow", pack(16'h01FF, 0, 1, 0, 0, 0, 0));
        step(1'b1, A_INC_A, IV_A, 8'hFF, 8'h55, 1'b0);
        expect_out("inc_a_wrap", pack(16'h0100, 1, 0, 0, 0, 0, 0));
        step(1'b1, A_DEC_B, IV_B, 8'h77, 8'h00, 1'b0);
        expect_out("dec_b_zero", pack(16'h01FF, 0, 1, 0, 0, 0, 0));
        step(1'b1, A_INC_B, IV_A, 8'h01, 8'h02, 1'b0);
        expect_out("inc_b_missing", pack(16'h0000, 0, 0, 0, 0, 0, 1));
        step(1'b1, A_CMP, IV_AB, 8'd5, 8'd9, 1'b0);
        expect_out("cmp_lt", pack(16'h0000, 0, 0, 0, 0, 1, 0));
        step(1'b1, A_CMP, IV_AB, 8'd7, 8'd7, 1'b0);
        expect_out("cmp_eq", pack(16'h0000, 0, 0, 0, 1, 0, 0));
        step(1'b1, A_CMP, IV_AB, 8'd9, 8'd5, 1'b0);
        expect_out("cmp_gt", pack(16'h0000, 0, 0, 1, 0, 0, 0));
`ifdef ALU_MULT_EN
        step(1'b1, A_MUL_INC, IV_AB, 8'd2, 8'd3, 1'b0);
        expect_out("mul_first_cycle_hold", pack(16'h0000, 0, 0, 1, 0, 0, 0));
        step(1'b1, A_ADD, IV_NONE, 8'd0, 8'd0, 1'b0);
        expect_out("mul_inc_2_3", pack(16'd12, 0, 0, 0, 0, 0, 0));
`else
        step(1'b1, A_MUL_INC, IV_AB, 8'd2, 8'd3, 1'b0);
        expect_out("mul_disabled_err", pack(16'h0000, 0, 0, 0, 0, 0, 1));
`endif
        step(1'b1, 4'd11, IV_AB, 8'd1, 8'd1, 1'b0);
        expect_out("arith_illegal", pack(16'h0000, 0, 0, 0, 0, 0, 1));

        // Logical, plus hold behaviour
        step(1'b0, L_AND, IV_AB, 8'hF0, 8'h3C, 1'b0);
        expect_out("and", pack(16'h0030, 0, 0, 0, 0, 0, 0));
        step(1'b1, A_SUB, IV_NONE, 8'h01, 8'h02, 1'b0);
        expect_out("iv00_hold", pack(16'h0030, 0, 0, 0, 0, 0, 0));
        ce = 1'b0;
        step(1'b0, L_XOR, IV_AB, 8'hF0, 8'h3C, 1'b0);
        expect_out("ce0_hold", pack(16'h0030, 0, 0, 0, 0, 0, 0));
        ce = 1'b1;
        step(1'b0, L_NAND, IV_AB, 8'hF0, 8'h3C, 1'b0);
        expect_out("nand", pack(16'h00CF, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_XOR, IV_AB, 8'hF0, 8'h3C, 1'b0);
        expect_out("xor", pack(16'h00CC, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_NOT_A, IV_A, 8'h0F, 8'h00, 1'b0);
        expect_out("not_a", pack(16'h00F0, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_ROL, IV_AB, 8'h81, 8'h01, 1'b0);
        expect_out("rol_81_1", pack(16'h0003, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_ROL, IV_AB, 8'h81, 8'h10, 1'b0);
        expect_out("rol_bad_amount", pack(16'h0081, 0, 0, 0, 0, 0, 1));
        step(1'b0, L_ROR, IV_AB, 8'h01, 8'h03, 1'b0);
        expect_out("ror_01_3", pack(16'h0020, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_SHR_B, IV_B, 8'hFF, 8'h80, 1'b0);
        expect_out("shr_b", pack(16'h0040, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_SHL_A, IV_A, 8'h81, 8'h00, 1'b0);
        expect_out("shl_a_trunc", pack(16'h0002, 0, 0, 0, 0, 0, 0));
        step(1'b0, L_NOT_B, IV_A, 8'h81, 8'h00, 1'b0);
        expect_out("not_b_missing", pack(16'h0000, 0, 0, 0, 0, 0, 1));
        step(1'b0, 4'd14, IV_AB, 8'h81, 8'h00, 1'b0);
        expect_out("logic_illegal", pack(16'h0000, 0, 0, 0, 0, 0, 1));

        // Split delivery: A now, B five cycles later; new CMD/MODE ignored
        step(1'b1, A_ADD, IV_A, 8'd3, 8'hEE, 1'b0);
        expect_state("split_enter_wait", WS_WAIT);
        expect_out("split_hold", pack(16'h0000, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) step(1'b0, L_AND, IV_NONE, 8'h99, 8'h99, 1'b0);
        expect_state("split_still_wait", WS_WAIT);
        step(1'b0, L_OR, IV_B, 8'hAA, 8'd4, 1'b0);
        expect_out("split_add_3_4", pack(16'h0007, 0, 0, 0, 0, 0, 0));
        expect_state("split_back_idle", WS_IDLE);

        // Latched B with IV=11 arrival: 9 - 4
        step(1'b1, A_SUB, IV_B, 8'h11, 8'd4, 1'b0);
        step(1'b1, A_ADD, IV_AB, 8'd9, 8'h63, 1'b0);
        expect_out("split_sub_latched_b", pack(16'h0005, 0, 0, 0, 0, 0, 0));

        // Timeout with CE freeze in the middle (arrival ignored while CE=0)
        step(1'b1, A_ADD, IV_A, 8'd3, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, A_ADD, IV_NONE, 8'd0, 8'd0, 1'b0);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, A_ADD, IV_B, 8'd0, 8'd4, 1'b0);
        ce = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, A_ADD, IV_NONE, 8'd0, 8'd0, 1'b0);
        expect_state("timeout_last_wait", WS_WAIT);
        expect_out("timeout_not_yet", pack(16'h0005, 0, 0, 0, 0, 0, 0));
        step(1'b1, A_ADD, IV_NONE, 8'd0, 8'd0, 1'b0);
        expect_out("timeout_err", pack(16'h0000, 0, 0, 0, 0, 0, 1));
        expect_state("timeout_idle", WS_IDLE);

        // Reset while waiting
        step(1'b1, A_ADD, IV_AB, 8'd1, 8'd1, 1'b0);
        expect_out("pre_rst_add", pack(16'h0002, 0, 0, 0, 0, 0, 0));
        step(1'b1, A_ADD, IV_B, 8'd0, 8'd5, 1'b0);
        step(1'b1, A_ADD, IV_NONE, 8'd0, 8'd0, 1'b0);
        expect_state("pre_rst_wait", WS_WAIT);
        rst = 1'b1;
        step(1'b1, A_ADD, IV_A, 8'd7, 8'd0, 1'b0);
        expect_out("rst_in_wait", pack(16'h0000, 0, 0, 0, 0, 0, 0));
        expect_state("rst_in_wait_state", WS_IDLE);
        rst = 1'b0;
        step(1'b1, A_INC_A, IV_A, 8'h41, 8'h00, 1'b0);
        expect_out("post_rst_inc", pack(16'h0042, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
